fetch_queue: RTL and testbench

Instruction fetch stage that sits directly upstream of the decoder. It owns the fetch PC and issues word reads to a synchronous-read instruction memory. Returned words are buffered in a small prefetch queue and handed to the decoder through a valid/ready handshake. A redirect from the branch/jump resolution logic (PCSrc/JumpSrc/JRetSrc target) flushes all queued and in-flight instructions and restarts fetch at the new target.

---
 rtl/fetch_queue.sv | 141 ++++++++++++++
 tb/tb_fetch_queue.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage feeding the decoder.
// Owns the fetch PC and issues word reads to a synchronous-read instruction
// memory. It buffers the returned words in a small prefetch queue and hands
// them out with a valid/ready handshake. A redirect flushes every queued and
// in-flight instruction.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN. When it is defined, a
// misaligned redirect target raises a sticky fetch_fault and halts fetch.
// When it is undefined, the low two bits of the target are cleared.
module fetch_queue #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           QDEPTH     = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_target,
  output logic                  fetch_fault
);

  localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CntW = $clog2(QDEPTH + 1);
  localparam logic [CntW:0] QDepthW = (CntW + 1)'(QDEPTH);
  localparam logic [DATA_WIDTH-1:0] Four = DATA_WIDTH'(4);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] fetch_pc_q;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] inflight_pc_q;
  logic [PtrW-1:0]       rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]       count_q;
  logic                  fault_q;
  logic [DATA_WIDTH-1:0] q_instr [QDEPTH];
  logic [DATA_WIDTH-1:0] q_pc    [QDEPTH];

  logic                  run;
  logic [CntW:0]         occupancy;
  logic [DATA_WIDTH-1:0] target;
  logic                  misaligned;
  logic                  push;
  logic                  pop;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign target     = redirect_target;
  assign misaligned = |redirect_target[1:0];
`else
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^redirect_target[1:0];
  assign target     = {redirect_target[DATA_WIDTH-1:2], 2'b00};
  assign misaligned = 1'b0;
`endif

  assign run       = (state_q == StRun);
  // Credit counts queued entries plus the outstanding read. A same-cycle pop
  // is deliberately not credited, so the request path does not depend on ready.
  assign occupancy = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};

  assign imem_req    = !rst && run && !redirect && (occupancy < QDepthW);
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = run && (count_q != '0);
  assign instr       = q_instr[rd_ptr_q];
  assign pc_o        = q_pc[rd_ptr_q];
  assign pc_plus4    = q_pc[rd_ptr_q] + Four;
  assign fetch_fault = fault_q;

  // A response that arrives in a redirect cycle is dropped.
  assign push = inflight_q && !(run && redirect);
  assign pop  = instr_valid && instr_ready;

  // Control FSM: fetch PC, in-flight tracking, queue pointers and fault flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StRun;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      fault_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (redirect) begin
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            inflight_q <= 1'b0;
            fetch_pc_q <= target;
            if (misaligned) begin
              state_q <= StHalt;
              fault_q <= 1'b1;
            end
          end else begin
            if (imem_req) begin
              fetch_pc_q    <= fetch_pc_q + Four;
              inflight_q    <= 1'b1;
              inflight_pc_q <= fetch_pc_q;
            end else begin
              inflight_q <= 1'b0;
            end
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            if (push && !pop)      count_q <= count_q + CntW'(1);
            else if (!push && pop) count_q <= count_q - CntW'(1);
          end
        end
        StHalt: begin
          // Only reset leaves HALT; keep the queue empty and fetch idle.
          count_q    <= '0;
          inflight_q <= 1'b0;
        end
        default: state_q <= StRun;
      endcase
    end
  end

  // Queue storage: write the returning word with the PC it was fetched from.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(QDEPTH); i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (push && run) begin
      q_instr[wr_ptr_q] <= imem_rdata;
      q_pc[wr_ptr_q]    <= inflight_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a randomized
// run scored against a sequential-PC reference model.
module tb_fetch_queue;

  localparam int unsigned QD  = 4;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr, pc_o, pc_plus4;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        fetch_fault;

  int vectors = 0;
  int miscompares = 0;

  fetch_queue #(
    .DATA_WIDTH(32),
    .QDEPTH    (QD),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .instr          (instr),
    .pc_o           (pc_o),
    .pc_plus4       (pc_plus4),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory: word content is addr ^ KEY.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr ^ KEY;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after release, at the start of cycle 0.
  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    redirect = 1'b0;
    redirect_target = '0;
    instr_ready = rdy;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    redirect = 1'b0;
    instr_ready = 1'b0;
    next_cycle();
    @(negedge clk);
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++; $display("FAIL reset_req got %b expected 0", imem_req);
    end
    vectors++;
    if (imem_addr !== 32'h0) begin
      miscompares++; $display("FAIL reset_addr got %h expected 0", imem_addr);
    end
    vectors++;
    if (instr !== 32'h0 || pc_o !== 32'h0) begin
      miscompares++; $display("FAIL reset_head got instr %h pc %h expected 0 0", instr, pc_o);
    end
    vectors++;
    if (pc_plus4 !== 32'h4) begin
      miscompares++; $display("FAIL reset_pc_plus4 got %h expected 4", pc_plus4);
    end
    vectors++;
    if (instr_valid !== 1'b0 || fetch_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags got valid %b fault %b expected 0 0", instr_valid, fetch_fault);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset(1'b1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) begin
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
          miscompares++;
          $display("FAIL stream_first_req got req %b addr %h expected 1 0", imem_req, imem_addr);
        end
      end
      if (c < 2) begin
        vectors++;
        if (instr_valid !== 1'b0) begin
          miscompares++; $display("FAIL stream_fill c%0d got valid %b expected 0", c, instr_valid);
        end
      end else begin
        exp_pc = 32'((c - 2) * 4);
        vectors++;
        if (instr_valid !== 1'b1 || pc_o !== exp_pc || instr !== (exp_pc ^ KEY) ||
            pc_plus4 !== exp_pc + 32'd4) begin
          miscompares++;
          $display("FAIL stream_seq c%0d got v%b pc %h instr %h expected pc %h instr %h",
                   c, instr_valid, pc_o, instr, exp_pc, exp_pc ^ KEY);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    int reqs;
    logic [31:0] exp_pc;
    reqs = 0;
    do_reset(1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (imem_req === 1'b1) begin
        vectors++;
        if (imem_addr !== 32'(reqs * 4) || c >= int'(QD)) begin
          miscompares++;
          $display("FAIL bp_req c%0d got addr %h expected addr %h before cycle %0d",
                   c, imem_addr, 32'(reqs * 4), QD);
        end
        reqs++;
      end
      next_cycle();
    end
    vectors++;
    if (reqs != int'(QD)) begin
      miscompares++; $display("FAIL bp_req_count got %0d expected %0d", reqs, QD);
    end
    instr_ready = 1'b1;
    for (int c = 10; c < 15; c++) begin
      @(negedge clk);
      exp_pc = 32'((c - 10) * 4);
      vectors++;
      if (instr_valid !== 1'b1 || pc_o !== exp_pc) begin
        miscompares++;
        $display("FAIL bp_drain c%0d got v%b pc %h expected pc %h", c, instr_valid, pc_o, exp_pc);
      end
      if (c == 10) begin
        vectors++;
        if (imem_req !== 1'b0) begin
          miscompares++; $display("FAIL bp_no_credit got req %b expected 0", imem_req);
        end
      end
      if (c == 11) begin
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
          miscompares++;
          $display("FAIL bp_resume got req %b addr %h expected 1 10", imem_req, imem_addr);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect();
    logic [31:0] exp_pc;
    do_reset(1'b0);
    for (int c = 0; c < 4; c++) next_cycle();
    // Cycle 4: entries 0,4,8 queued and 0xC in flight.
    redirect = 1'b1;
    redirect_target = 32'h100;
    @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b1 || pc_o !== 32'h0 || imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_t got v%b pc %h req %b expected 1 0 0", instr_valid, pc_o, imem_req);
    end
    next_cycle();
    redirect = 1'b0;
    @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      miscompares++;
      $display("FAIL redir_t1 got v%b req %b addr %h expected 0 1 100",
               instr_valid, imem_req, imem_addr);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b0) begin
      miscompares++; $display("FAIL redir_t2 got valid %b expected 0", instr_valid);
    end
    next_cycle();
    instr_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_pc = 32'h100 + 32'(k * 4);
      vectors++;
      if (instr_valid !== 1'b1 || pc_o !== exp_pc || instr !== (exp_pc ^ KEY)) begin
        miscompares++;
        $display("FAIL redir_deliver t+%0d got v%b pc %h expected pc %h",
                 k + 3, instr_valid, pc_o, exp_pc);
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1'b1);
    for (int c = 0; c < 5; c++) next_cycle();
    redirect = 1'b1;
    redirect_target = 32'h200;
    next_cycle();
    redirect_target = 32'h300;
    @(negedge clk);
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++; $display("FAIL b2b_t1 got req %b expected 0", imem_req);
    end
    next_cycle();
    redirect = 1'b0;
    @(negedge clk);
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h300 || instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_t2 got req %b addr %h v%b expected 1 300 0",
               imem_req, imem_addr, instr_valid);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b0) begin
      miscompares++; $display("FAIL b2b_t3 got valid %b expected 0", instr_valid);
    end
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vectors++;
      if (instr_valid !== 1'b1 || pc_o !== 32'h300 + 32'(k * 4)) begin
        miscompares++;
        $display("FAIL b2b_deliver t+%0d got v%b pc %h expected %h",
                 k + 4, instr_valid, pc_o, 32'h300 + 32'(k * 4));
      end
      next_cycle();
    end
  endtask

  task automatic test_misalign();
    do_reset(1'b1);
    for (int c = 0; c < 3; c++) next_cycle();
    redirect = 1'b1;
    redirect_target = 32'h102;
    next_cycle();
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    @(negedge clk);
    vectors++;
    if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_t1 got fault %b req %b v%b expected 1 0 0",
               fetch_fault, imem_req, instr_valid);
    end
    next_cycle();
    redirect = 1'b1;
    redirect_target = 32'h40;
    next_cycle();
    redirect = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++;
      if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL misalign_halt k%0d got fault %b req %b v%b expected 1 0 0",
                 k, fetch_fault, imem_req, instr_valid);
      end
      next_cycle();
    end
`else
    @(negedge clk);
    vectors++;
    if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      miscompares++;
      $display("FAIL misalign_t1 got fault %b req %b addr %h expected 0 1 100",
               fetch_fault, imem_req, imem_addr);
    end
    next_cycle();
    next_cycle();
    @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b1 || pc_o !== 32'h100) begin
      miscompares++;
      $display("FAIL misalign_t3 got v%b pc %h expected 1 100", instr_valid, pc_o);
    end
    next_cycle();
`endif
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    for (int c = 0; c < 3; c++) next_cycle();
    @(negedge clk);
    vectors++;
    if (instr_valid !== 1'b1 || pc_o !== 32'h0) begin
      miscompares++;
      $display("FAIL rstmid_pre got v%b pc %h expected 1 0", instr_valid, pc_o);
    end
    next_cycle();
    rst = 1'b1;
    #1;
    vectors++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL rstmid_async got v%b req %b addr %h expected 0 0 0",
               instr_valid, imem_req, imem_addr);
    end
    next_cycle();
    rst = 1'b0;
    instr_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
          miscompares++;
          $display("FAIL rstmid_restart got req %b addr %h expected 1 0", imem_req, imem_addr);
        end
      end
      if (c >= 2) begin
        vectors++;
        if (instr_valid !== 1'b1 || pc_o !== 32'((c - 2) * 4) ||
            instr !== (32'((c - 2) * 4) ^ KEY)) begin
          miscompares++;
          $display("FAIL rstmid_deliver c%0d got v%b pc %h instr %h expected pc %h",
                   c, instr_valid, pc_o, instr, 32'((c - 2) * 4));
        end
      end
      next_cycle();
    end
  endtask

  // Reference model: delivered PCs run sequentially from the last redirect
  // target (or reset PC); outstanding = requests issued minus pops since flush.
  task automatic test_random();
    logic [31:0] exp_pc, tgt, prev_pc, prev_instr;
    int outstanding, pops;
    logic hold, exp_req, popped;
    exp_pc = 32'h0;
    outstanding = 0;
    pops = 0;
    hold = 1'b0;
    prev_pc = '0;
    prev_instr = '0;
    do_reset(1'b1);
    for (int c = 0; c < 600; c++) begin
      instr_ready = ($urandom_range(3) != 0);
      redirect = ($urandom_range(19) == 0);
      tgt = $urandom & 32'h0000_FFFC;
`ifndef FETCH_MISALIGN_CHECK_EN
      tgt = tgt | 32'($urandom_range(3));
`endif
      redirect_target = tgt;
      @(negedge clk);
      if (hold) begin
        vectors++;
        if (instr_valid !== 1'b1 || pc_o !== prev_pc || instr !== prev_instr) begin
          miscompares++;
          $display("FAIL rand_hold c%0d got v%b pc %h expected pc %h", c, instr_valid, pc_o,
                   prev_pc);
        end
      end
      exp_req = !redirect && (outstanding < int'(QD));
      vectors++;
      if (imem_req !== exp_req) begin
        miscompares++;
        $display("FAIL rand_req c%0d got %b expected %b", c, imem_req, exp_req);
      end
      popped = instr_valid && instr_ready;
      if (popped) begin
        vectors++;
        if (pc_o !== exp_pc || instr !== (exp_pc ^ KEY) || pc_plus4 !== exp_pc + 32'd4) begin
          miscompares++;
          $display("FAIL rand_pop c%0d got pc %h instr %h expected pc %h instr %h",
                   c, pc_o, instr, exp_pc, exp_pc ^ KEY);
        end
      end
      if (redirect) begin
        exp_pc = {tgt[31:2], 2'b00};
        outstanding = 0;
      end else begin
        if (popped) begin
          exp_pc = exp_pc + 32'd4;
          outstanding--;
          pops++;
        end
        if (imem_req === 1'b1) outstanding++;
      end
      vectors++;
      if (outstanding > int'(QD) || outstanding < 0) begin
        miscompares++;
        $display("FAIL rand_overflow c%0d got occupancy %0d expected at most %0d",
                 c, outstanding, QD);
      end
      hold = instr_valid && !instr_ready && !redirect;
      prev_pc = pc_o;
      prev_instr = instr;
      next_cycle();
    end
    redirect = 1'b0;
    vectors++;
    if (pops < 150) begin
      miscompares++; $display("FAIL rand_throughput got %0d pops expected at least 150", pops);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
